// File: rtl/irq_ack_ctrl_pkg.sv
// Shared types and constants for the interrupt acknowledge controller.
package irq_ack_ctrl_pkg;

  // Width of an interrupt vector as delivered to the core.
  localparam int VEC_W = 8;

  // x86 NMI vector.
  localparam logic [VEC_W-1:0] NMI_VECTOR_DEF = 8'h02;

  // Maskable-interrupt handshake states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACK   = 2'd2,
    ST_GUARD = 2'd3
  } intr_state_e;

  // Number of bits needed to hold any value in 0..max_val (at least 1).
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/irq_ack_ctrl_sync_edge.sv
// N-stage synchroniser followed by a rising-edge detector. Usable for any
// asynchronous single-bit input that must be sampled in the clk domain.
module irq_ack_ctrl_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Shift the asynchronous input through the chain and remember the last
  // synchronised value for edge detection.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], async_in};
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser and edge-history registers.
  // NOTE: reset is synchronous here because the surrounding codebase
  // resets that way; the reset branch lives inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // flop samples the pre-edge value of its sources.
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ack_ctrl.sv
// Interrupt acknowledge controller between the cascaded 8259 pair and the
// 486 core. Presents INTR/NMI, latches the delivered vector, returns a
// single-cycle done pulse to the PIC, and holds off re-requesting INTR for a
// guard window so the PIC's still-high interrupt_do is not taken twice.
module irq_ack_ctrl
  import irq_ack_ctrl_pkg::*;
#(
  parameter int               GUARD_CYCLES = 2,
  parameter logic [VEC_W-1:0] NMI_VECTOR   = NMI_VECTOR_DEF,
  parameter int               SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pic_interrupt_do,
  input  logic [7:0] pic_interrupt_vector,
  output logic       pic_interrupt_done,
  input  logic       nmi_in,
  output logic       cpu_intr_req,
  input  logic       cpu_intr_ack,
  output logic       cpu_nmi_req,
  input  logic       cpu_nmi_ack,
  input  logic       cpu_nmi_iret,
  output logic       vec_valid,
  output logic [7:0] vec
);

  localparam int CNT_W = cnt_width(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  intr_state_e      state_q, state_d;
  logic [CNT_W-1:0] guard_cnt_q, guard_cnt_d;
  logic             nmi_pending_q, nmi_pending_d;
  logic             nmi_blocked_q, nmi_blocked_d;
  logic [7:0]       vec_q, vec_d;
  logic             vec_valid_q, vec_valid_d;

  logic             nmi_rise;
  logic             nmi_req;
  logic             nmi_take;
  logic             intr_take;

  irq_ack_ctrl_sync_edge #(
    .STAGES (SYNC_STAGES)
  ) u_nmi_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (nmi_in),
    .rise     (nmi_rise)
  );

  // NMI is offered whenever one is latched and no NMI handler is active;
  // it outranks INTR, so a simultaneous NMI ack vetoes the INTR ack.
  assign nmi_req   = nmi_pending_q & ~nmi_blocked_q;
  assign nmi_take  = cpu_nmi_ack & nmi_req;
  assign intr_take = (state_q == ST_REQ) & cpu_intr_ack & ~cpu_nmi_ack;

  // INTR handshake next-state logic. An ack in REQ is honoured even if
  // interrupt_do is falling that cycle: the PIC then supplies its spurious
  // vector and still needs the done pulse to close its own handshake.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch
    // is inferred.
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pic_interrupt_do) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (intr_take)             state_d = ST_ACK;
        else if (!pic_interrupt_do) state_d = ST_IDLE;
      end
      ST_ACK: begin
        state_d     = ST_GUARD;
        guard_cnt_d = GUARD_LOAD;
      end
      ST_GUARD: begin
        if (guard_cnt_q == '0) state_d = ST_IDLE;
        else                   guard_cnt_d = guard_cnt_q - CNT_W'(1);
      end
      default: begin
        state_d     = ST_IDLE;
        guard_cnt_d = '0;
      end
    endcase
  end

  // NMI latch and x86-style blocking until IRET. A new edge arriving on the
  // same cycle as the ack re-arms pending, so that NMI follows the IRET.
  always_comb begin
    nmi_pending_d = nmi_pending_q;
    nmi_blocked_d = nmi_blocked_q;
    if (nmi_take)          nmi_pending_d = 1'b0;
    if (nmi_rise)          nmi_pending_d = 1'b1;
    if (nmi_take)          nmi_blocked_d = 1'b1;
    else if (cpu_nmi_iret) nmi_blocked_d = 1'b0;
  end

  // Vector capture: one strobe per delivered interrupt; vec holds otherwise.
  always_comb begin
    vec_d       = vec_q;
    vec_valid_d = 1'b0;
    if (nmi_take) begin
      vec_d       = NMI_VECTOR;
      vec_valid_d = 1'b1;
    end else if (intr_take) begin
      vec_d       = pic_interrupt_vector;
      vec_valid_d = 1'b1;
    end
  end

  // State registers; reset returns every flop, including mid-handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      guard_cnt_q   <= '0;
      nmi_pending_q <= 1'b0;
      nmi_blocked_q <= 1'b0;
      vec_q         <= '0;
      vec_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      guard_cnt_q   <= guard_cnt_d;
      nmi_pending_q <= nmi_pending_d;
      nmi_blocked_q <= nmi_blocked_d;
      vec_q         <= vec_d;
      vec_valid_q   <= vec_valid_d;
    end
  end

  assign pic_interrupt_done = (state_q == ST_ACK);
  assign cpu_intr_req       = (state_q == ST_REQ) & pic_interrupt_do & ~nmi_req;
  assign cpu_nmi_req        = nmi_req;
  assign vec_valid          = vec_valid_q;
  assign vec                = vec_q;

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// Directed bench for irq_ack_ctrl: INTR handshake and guard window, request
// withdrawal, ack on falling request, NMI latch/block/IRET, NMI priority and
// reset in the middle of a handshake.
module tb_irq_ack_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pic_interrupt_do;
  logic [7:0] pic_interrupt_vector;
  logic       pic_interrupt_done;
  logic       nmi_in;
  logic       cpu_intr_req;
  logic       cpu_intr_ack;
  logic       cpu_nmi_req;
  logic       cpu_nmi_ack;
  logic       cpu_nmi_iret;
  logic       vec_valid;
  logic [7:0] vec;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  irq_ack_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .pic_interrupt_do     (pic_interrupt_do),
    .pic_interrupt_vector (pic_interrupt_vector),
    .pic_interrupt_done   (pic_interrupt_done),
    .nmi_in               (nmi_in),
    .cpu_intr_req         (cpu_intr_req),
    .cpu_intr_ack         (cpu_intr_ack),
    .cpu_nmi_req          (cpu_nmi_req),
    .cpu_nmi_ack          (cpu_nmi_ack),
    .cpu_nmi_iret         (cpu_nmi_iret),
    .vec_valid            (vec_valid),
    .vec                  (vec)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int waited;

    rst_n                = 1'b0;
    pic_interrupt_do     = 1'b0;
    pic_interrupt_vector = 8'h00;
    nmi_in               = 1'b0;
    cpu_intr_ack         = 1'b0;
    cpu_nmi_ack          = 1'b0;
    cpu_nmi_iret         = 1'b0;

    // ---------------- reset state
    repeat (3) tick();
    check("rst_done",      pic_interrupt_done, 0);
    check("rst_intr_req",  cpu_intr_req,       0);
    check("rst_nmi_req",   cpu_nmi_req,        0);
    check("rst_vec_valid", vec_valid,          0);
    check("rst_vec",       vec,                8'h00);
    rst_n = 1'b1;
    tick();

    // ---------------- INTR basic, vector 08
    pic_interrupt_do     = 1'b1;
    pic_interrupt_vector = 8'h08;
    tick();                          // IDLE -> REQ
    check("basic_req",      cpu_intr_req,       1);
    check("basic_pre_done", pic_interrupt_done, 0);
    cpu_intr_ack = 1'b1;
    tick();                          // ack sampled -> ACK
    cpu_intr_ack = 1'b0;
    settle();
    check("basic_vec_valid", vec_valid,          1);
    check("basic_vec",       vec,                8'h08);
    check("basic_done",      pic_interrupt_done, 1);
    check("basic_req_ack",   cpu_intr_req,       0);
    tick();                          // GUARD, first cycle
    check("basic_g1_valid", vec_valid,          0);
    check("basic_g1_done",  pic_interrupt_done, 0);
    check("basic_g1_req",   cpu_intr_req,       0);
    check("basic_vec_hold", vec,                8'h08);
    tick();                          // GUARD, second cycle
    check("basic_g2_req",   cpu_intr_req,       0);
    check("basic_g2_done",  pic_interrupt_done, 0);
    waited = 0;
    while (!cpu_intr_req && waited < 4) begin
      tick();
      waited++;
    end
    check("basic_rerequest", cpu_intr_req, 1);
    check("basic_no_dup_valid", vec_valid, 0);

    // ---------------- withdrawn request
    pic_interrupt_do = 1'b0;
    tick();                          // back to IDLE
    check("wd_idle_req", cpu_intr_req, 0);
    tick();
    pic_interrupt_do     = 1'b1;
    pic_interrupt_vector = 8'h0C;
    repeat (3) begin
      tick();
      check("wd_no_done",  pic_interrupt_done, 0);
      check("wd_no_valid", vec_valid,          0);
    end
    pic_interrupt_do = 1'b0;
    tick();                          // REQ -> IDLE, nothing signalled
    check("wd_drop_done",  pic_interrupt_done, 0);
    check("wd_drop_valid", vec_valid,          0);
    pic_interrupt_do = 1'b1;
    settle();
    check("wd_in_idle", cpu_intr_req, 0);   // IDLE never requests
    tick();                          // IDLE -> REQ
    check("wd_req_again", cpu_intr_req, 1);

    // ---------------- ack on the cycle interrupt_do falls
    pic_interrupt_do     = 1'b0;
    pic_interrupt_vector = 8'h0F;
    cpu_intr_ack         = 1'b1;
    tick();
    cpu_intr_ack = 1'b0;
    settle();
    check("fall_done",  pic_interrupt_done, 1);
    check("fall_valid", vec_valid,          1);
    check("fall_vec",   vec,                8'h0F);
    repeat (3) begin
      tick();
      check("fall_done_once", pic_interrupt_done, 0);
    end

    // ---------------- ack outside REQ is ignored
    cpu_intr_ack = 1'b1;
    tick();
    cpu_intr_ack = 1'b0;
    settle();
    check("stray_ack_done",  pic_interrupt_done, 0);
    check("stray_ack_valid", vec_valid,          0);
    check("stray_ack_vec",   vec,                8'h0F);

    // ---------------- NMI: latch, deliver, block
    nmi_in = 1'b1;
    waited = 0;
    while (!cpu_nmi_req && waited < 3) begin
      tick();
      waited++;
    end
    check("nmi_req_latency", cpu_nmi_req, 1);
    cpu_nmi_ack = 1'b1;
    tick();
    cpu_nmi_ack = 1'b0;
    settle();
    check("nmi_vec",        vec,                8'h02);
    check("nmi_valid",      vec_valid,          1);
    check("nmi_no_done",    pic_interrupt_done, 0);
    check("nmi_req_blocked", cpu_nmi_req,       0);
    tick();
    check("nmi_valid_once", vec_valid, 0);
    nmi_in = 1'b0;
    repeat (3) tick();
    nmi_in = 1'b1;                   // second edge while blocked
    repeat (4) tick();
    check("nmi_blocked_hold", cpu_nmi_req, 0);
    cpu_nmi_iret = 1'b1;
    tick();
    cpu_nmi_iret = 1'b0;
    settle();
    check("nmi_after_iret", cpu_nmi_req, 1);
    cpu_nmi_ack = 1'b1;
    tick();
    cpu_nmi_ack = 1'b0;
    settle();
    check("nmi2_valid", vec_valid, 1);
    cpu_nmi_iret = 1'b1;
    tick();
    cpu_nmi_iret = 1'b0;
    settle();
    check("nmi_drained", cpu_nmi_req, 0);
    nmi_in = 1'b0;
    repeat (3) tick();

    // ---------------- priority: NMI beats INTR
    nmi_in = 1'b1;
    repeat (3) tick();
    check("pri_nmi_req", cpu_nmi_req, 1);
    pic_interrupt_do     = 1'b1;
    pic_interrupt_vector = 8'h21;
    tick();                          // IDLE -> REQ, masked by NMI
    check("pri_intr_masked", cpu_intr_req, 0);
    cpu_intr_ack = 1'b1;
    cpu_nmi_ack  = 1'b1;
    tick();
    cpu_intr_ack = 1'b0;
    cpu_nmi_ack  = 1'b0;
    settle();
    check("pri_vec",     vec,                8'h02);
    check("pri_valid",   vec_valid,          1);
    check("pri_no_done", pic_interrupt_done, 0);
    check("pri_still_req", cpu_intr_req,     1);
    cpu_intr_ack = 1'b1;
    tick();
    cpu_intr_ack = 1'b0;
    settle();
    check("pri_intr_vec",   vec,                8'h21);
    check("pri_intr_valid", vec_valid,          1);
    check("pri_intr_done",  pic_interrupt_done, 1);
    pic_interrupt_do = 1'b0;
    nmi_in           = 1'b0;
    repeat (4) tick();
    cpu_nmi_iret = 1'b1;
    tick();
    cpu_nmi_iret = 1'b0;
    repeat (2) tick();

    // ---------------- reset during ACK
    pic_interrupt_do     = 1'b1;
    pic_interrupt_vector = 8'h33;
    tick();                          // REQ
    cpu_intr_ack = 1'b1;
    tick();                          // ACK
    cpu_intr_ack = 1'b0;
    settle();
    check("rstack_in_ack", pic_interrupt_done, 1);
    rst_n = 1'b0;
    tick();
    check("rstack_done",  pic_interrupt_done, 0);
    check("rstack_valid", vec_valid,          0);
    check("rstack_vec",   vec,                8'h00);
    check("rstack_intr",  cpu_intr_req,       0);
    check("rstack_nmi",   cpu_nmi_req,        0);
    rst_n            = 1'b1;
    pic_interrupt_do = 1'b0;
    repeat (3) begin
      tick();
      check("rstack_no_done", pic_interrupt_done, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
